// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// FSM state encodings, default timeout and the timeout counter width helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_e;

    localparam int DEFAULT_TIMEOUT = 16;

    // Counter must reach TIMEOUT-1; keep at least one bit for tiny timeouts.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_timeout_counter.sv
// Wait-state counter for one bus transaction; expire flags the last allowed
// cycle so the arbiter can abort a transaction that never sees an ack.
module mem_bus_arbiter_bus_timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, never wraps because the arbiter aborts at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory bus between the instruction-fetch and data ports,
// data first, holding a global stall until every requested access is done.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ren,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    state_e              state_q,     state_d;
    logic                bus_req_q,   bus_req_d;
    logic                bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   inst_data_q, inst_data_d;
    logic [DATA_W-1:0]   mem_din_q,   mem_din_d;
    logic                inst_done_q, inst_done_d;
    logic                data_done_q, data_done_d;
    logic                bus_err_q,   bus_err_d;

    logic                dreq_s;
    logic                ipend_s;
    logic                dpend_s;
    logic                stall_s;
    logic                finish_s;
    logic                inst_set_s;
    logic                data_set_s;
    logic                cnt_clear_s;
    logic                cnt_en_s;
    logic                cnt_expire_s;
    logic [DATA_W-1:0]   rdata_s;

    assign dreq_s  = mem_ren | mem_wen;
    assign ipend_s = inst_ren & ~inst_done_q;
    assign dpend_s = dreq_s & ~data_done_q;
    assign stall_s = ipend_s | dpend_s;

    mem_bus_arbiter_bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear_s),
        .enable (cnt_en_s),
        .expire (cnt_expire_s)
    );

    // Next-state logic: issue from IDLE, hold the bus request until ack or abort.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        inst_data_d = inst_data_q;
        mem_din_d   = mem_din_q;
        bus_err_d   = bus_err_q;
        finish_s    = 1'b0;
        inst_set_s  = 1'b0;
        data_set_s  = 1'b0;
        cnt_clear_s = 1'b1;
        cnt_en_s    = 1'b0;
        // An aborted transaction completes with zero read data.
        rdata_s     = bus_ack ? bus_rdata : '0;

        case (state_q)
            ST_IDLE: begin
                if (dpend_s) begin
                    state_d     = ST_DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_wen;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_dout;
                end else if (ipend_s) begin
                    state_d     = ST_INST;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = inst_addr;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_DATA, ST_INST: begin
                cnt_clear_s = 1'b0;
                cnt_en_s    = 1'b1;
                finish_s    = bus_ack | cnt_expire_s;
                if (finish_s) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    cnt_clear_s = 1'b1;
                    cnt_en_s    = 1'b0;
                    bus_err_d   = bus_err_q | ~bus_ack;
                    // A withdrawn request still completes on the bus but its result is dropped.
                    if (state_q == ST_DATA) begin
                        data_set_s = dreq_s;
                        if (dreq_s && !bus_we_q) begin
                            mem_din_d = rdata_s;
                        end else begin
                            mem_din_d = mem_din_q;
                        end
                    end else begin
                        inst_set_s = inst_ren;
                        if (inst_ren) begin
                            inst_data_d = rdata_s;
                        end else begin
                            inst_data_d = inst_data_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        // Done flags live only while the pipeline is stalled.
        if (stall_s) begin
            inst_done_d = inst_done_q | inst_set_s;
            data_done_d = data_done_q | data_set_s;
        end else begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            inst_data_q <= '0;
            mem_din_q   <= '0;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            inst_data_q <= inst_data_d;
            mem_din_q   <= mem_din_d;
            inst_done_q <= inst_done_d;
            data_done_q <= data_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall     = stall_s;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign inst_data = inst_data_q;
    assign mem_din   = mem_din_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a core driver pushes expected results,
// a wait-state memory answers the bus, and a monitor checks bus and core sides.
module tb_mem_bus_arbiter;

    localparam int TO    = 16;
    localparam int NEVER = -1;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    mem_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_ren  (inst_ren),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp_inst;
        logic [31:0] exp_din;
        int          exp_lat;
        int          issue_cyc;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    sb_t         sb_q[$];
    bus_t        bus_exp_q[$];
    int          lat_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    bit          force_ack = 1'b0;
    logic [31:0] force_rdata = 32'h0;
    logic [31:0] exp_inst_cur = 32'h0;
    logic [31:0] exp_din_cur  = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%08h expected=0x%08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_val(a);
    endfunction

    function automatic int keff(input int l);
        return (l < 0) ? TO - 1 : l;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Wait-state memory: ack arrives after the number of wait cycles queued by the driver.
    initial begin : responder
        bit in_txn;
        int wait_left;
        in_txn    = 1'b0;
        wait_left = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
            if (force_ack) begin
                bus_ack   = 1'b1;
                bus_rdata = force_rdata;
            end else if (bus_req === 1'b1) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_left = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end
                if (wait_left == 0) begin
                    bus_ack = 1'b1;
                    if (bus_we) bus_mem[bus_addr] = bus_wdata;
                    else        bus_rdata = bus_rd(bus_addr);
                    in_txn = 1'b0;
                end else if (wait_left > 0) begin
                    wait_left = wait_left - 1;
                end
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    // Monitor: pops expectations when the pipeline advances and when the bus starts a transaction.
    initial begin : monitor
        bit   prev_req;
        bit   have_cur;
        int   run_len;
        bus_t cur;
        sb_t  e;
        prev_req = 1'b0;
        have_cur = 1'b0;
        run_len  = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !stall && (inst_ren || mem_ren || mem_wen)) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_release", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("inst_data", inst_data, e.exp_inst);
                    check("mem_din", mem_din, e.exp_din);
                    check("release_latency", 32'(cyc - e.issue_cyc), 32'(e.exp_lat));
                end
            end
            if (bus_req === 1'b1 && !prev_req) begin
                have_cur = 1'b0;
                run_len  = 1;
                if (mon_en) begin
                    if (bus_exp_q.size() == 0) begin
                        check("bus_unexpected_req", 32'd1, 32'd0);
                    end else begin
                        cur      = bus_exp_q.pop_front();
                        have_cur = 1'b1;
                        check("bus_addr", bus_addr, cur.addr);
                        check("bus_we", 32'(bus_we), 32'(cur.we));
                        if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
                    end
                end
            end else if (bus_req === 1'b1) begin
                run_len = run_len + 1;
                if (have_cur) check("bus_addr_stable", bus_addr, cur.addr);
            end else if (prev_req && have_cur) begin
                check("bus_req_len", 32'(run_len), 32'(cur.len));
                have_cur = 1'b0;
            end
            prev_req = (bus_req === 1'b1);
        end
    end

    // Issue one core access bundle (called just after a rising edge) and wait for release.
    task automatic run_bundle(input bit i_en, input logic [31:0] ia, input int dop,
                              input logic [31:0] da, input logic [31:0] wd,
                              input int lat_d, input int lat_i);
        sb_t  e;
        bus_t b;
        int   n;
        e.exp_lat = 0;
        if (dop != 0) begin
            b.addr = da; b.we = (dop == 2); b.wdata = wd;
            b.len  = (lat_d < 0) ? TO : lat_d + 1;
            bus_exp_q.push_back(b);
            lat_q.push_back(lat_d);
            if (dop == 1) exp_din_cur = (lat_d < 0) ? 32'h0 : ref_rd(da);
            else if (lat_d >= 0) ref_mem[da] = wd;
            e.exp_lat = keff(lat_d) + 2;
        end
        if (i_en) begin
            b.addr = ia; b.we = 1'b0; b.wdata = 32'h0;
            b.len  = (lat_i < 0) ? TO : lat_i + 1;
            bus_exp_q.push_back(b);
            lat_q.push_back(lat_i);
            exp_inst_cur = (lat_i < 0) ? 32'h0 : ref_rd(ia);
            e.exp_lat = (dop != 0) ? e.exp_lat + keff(lat_i) + 2 : keff(lat_i) + 2;
        end
        e.exp_inst  = exp_inst_cur;
        e.exp_din   = exp_din_cur;
        e.issue_cyc = cyc;
        sb_q.push_back(e);
        inst_ren  = i_en;
        inst_addr = ia;
        mem_ren   = (dop == 1);
        mem_wen   = (dop == 2);
        mem_addr  = da;
        mem_dout  = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n = n + 1;
            if (n > 200) begin
                check("stall_release_timeout", 32'(stall), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        inst_ren = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst = 1'b1; inst_ren = 1'b0; inst_addr = 32'h0; mem_ren = 1'b0; mem_wen = 1'b0;
        mem_addr = 32'h0; mem_dout = 32'h0;
        ref_mem[32'h100] = 32'h2408_000A;
        bus_mem[32'h100] = 32'h2408_000A;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_bundle(1'b1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
        run_bundle(1'b1, 32'h104, 1, 32'h2000, 32'h0, 3, 3);
        run_bundle(1'b0, 32'h0, 2, 32'h40, 32'hDEAD_BEEF, 2, 0);

        for (int t = 0; t < 40; t++) begin
            bit i_en;
            int dop;
            i_en = 1'($urandom_range(0, 1));
            dop  = $urandom_range(0, 2);
            if (!i_en && dop == 0) i_en = 1'b1;
            run_bundle(i_en, 32'h100 + 32'($urandom_range(0, 15) << 2), dop,
                       32'h40 + 32'($urandom_range(0, 15) << 2), $urandom,
                       $urandom_range(0, 4), $urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        check("no_err_before_timeout", 32'(bus_err), 32'd0);

        run_bundle(1'b0, 32'h0, 1, 32'h44, 32'h0, NEVER, 0);
        check("timeout_bus_err", 32'(bus_err), 32'd1);
        run_bundle(1'b1, 32'h108, 0, 32'h0, 32'h0, 0, 1);
        check("bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a data transaction, then a stray ack in IDLE.
        mon_en = 1'b0;
        mem_ren = 1'b1; mem_addr = 32'h48;
        lat_q.push_back(NEVER);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_ren = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_bus_req", 32'(bus_req), 32'd0);
        check("midrst_bus_we", 32'(bus_we), 32'd0);
        check("midrst_bus_addr", bus_addr, 32'h0);
        check("midrst_bus_wdata", bus_wdata, 32'h0);
        check("midrst_inst_data", inst_data, 32'h0);
        check("midrst_mem_din", mem_din, 32'h0);
        check("midrst_bus_err", 32'(bus_err), 32'd0);
        force_rdata = 32'hFFFF_FFFF;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        check("late_ack_bus_req", 32'(bus_req), 32'd0);
        check("late_ack_mem_din", mem_din, 32'h0);
        check("late_ack_inst_data", inst_data, 32'h0);
        check("late_ack_stall", 32'(stall), 32'd0);
        exp_inst_cur = 32'h0;
        exp_din_cur  = 32'h0;

        // Flush: instruction request withdrawn while the bus waits.
        @(posedge clk); #1;
        inst_ren = 1'b1; inst_addr = 32'h180;
        lat_q.push_back(4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        inst_ren = 1'b0;
        @(negedge clk);
        check("flush_stall", 32'(stall), 32'd0);
        n = 0;
        while (bus_req === 1'b1 && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        check("flush_bus_req_done", 32'(bus_req), 32'd0);
        check("flush_inst_data", inst_data, exp_inst_cur);
        check("flush_stall_after", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_bundle(1'b1, 32'h200, 0, 32'h0, 32'h0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("bus_exp_drained", 32'(bus_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one wait-state memory bus (req/ack handshake) between the core's instruction-fetch port and its data port.
- Sits between the core's instruction/memory interfaces and a single unified memory.
- Serialises accesses; data port has priority.
- Drives one global pipeline stall until every access the core asks for in the current cycle is done. Also bounds each bus transaction with a timeout.

Parameters:
ADDR_W, 32, address width of core ports and bus
DATA_W, 32, data width
TIMEOUT, 16, maximum cycles bus_req is held waiting for bus_ack before abort (>=2)

Ports:
clk  input  1  main clock
rst  input  1  reset; synchronous, active-high
inst_ren  input  1  instruction read request; held stable by core while stall=1
inst_addr  input  ADDR_W  instruction address
inst_data  output  DATA_W  fetched instruction (registered)
mem_ren  input  1  data read request
mem_wen  input  1  data write request (mem_ren and mem_wen never both 1)
mem_addr  input  ADDR_W  data address
mem_dout  input  DATA_W  core write data
mem_din  output  DATA_W  data read result (registered)
stall  output  1  global pipeline stall
bus_req  output  1  bus request (registered)
bus_we  output  1  bus write enable (registered)
bus_addr  output  ADDR_W  bus address (registered)
bus_wdata  output  DATA_W  bus write data (registered)
bus_rdata  input  DATA_W  bus read data, valid when bus_ack=1
bus_ack  input  1  bus completion, single-cycle pulse
bus_err  output  1  sticky timeout flag

Behaviour:
- Reset: rst=1 at a clk edge forces state IDLE and clears to 0:
  - bus_req, bus_we, bus_addr, bus_wdata
  - inst_data, mem_din
  - inst_done, data_done, timeout counter, bus_err
- Reset mid-transaction abandons it; bus_req is 0 in the cycle after the reset edge.
- Request flags (combinational):
  - ipend = inst_ren & ~inst_done
  - dpend = (mem_ren | mem_wen) & ~data_done
- stall = ipend | dpend (combinational). It is 0 with no requests.
- Done flags:
  - Set on the matching completion.
  - Both clear at any edge where stall=0, i.e. when the pipeline advances.
  - A port already done is never reissued while the other port is still pending.
- FSM states: IDLE, DATA, INST.
- IDLE:
  - If dpend: latch mem_addr, mem_dout and bus_we=mem_wen; bus_req=1; go to DATA.
  - Else if ipend: latch inst_addr, bus_we=0; bus_req=1; go to INST.
  - Else stay.
- DATA / INST:
  - bus_req, bus_we, bus_addr and bus_wdata are held stable.
  - The counter increments each cycle.
  - On bus_ack=1:
    - bus_req=0, counter cleared, go to IDLE.
    - If the request is still asserted, set the port's done flag.
    - Reads latch bus_rdata into mem_din (DATA) or inst_data (INST). Writes leave mem_din unchanged.
  - On timeout (counter == TIMEOUT-1 with no ack): treat as completion, latch 0 as read data, set bus_err, go to IDLE.
- Latency:
  - Request first seen in cycle 0; bus_req=1 in cycle 1.
  - If ack arrives in cycle k, done is set at the end of cycle k and stall=0 in cycle k+1, with data valid on inst_data/mem_din.
  - Minimum 2 cycles from request to stall release for a single port.
- Simultaneous inst and data requests: DATA completes first, then one IDLE cycle, then INST.
- Bubble cycle: one IDLE cycle always separates transactions. No back-to-back bus_req without a low cycle.
- Withdrawn request: if the core drops a request mid-transaction (flush), the transaction still completes. Result is discarded and no done flag is set.
- bus_ack while in IDLE is ignored.
- Counter is ceil(log2(TIMEOUT)) bits wide; it never wraps because of the abort at TIMEOUT-1.
- bus_err clears only on rst.

Decomposition:
- Shared header (define.vh style): state encodings ST_IDLE/ST_DATA/ST_INST, default TIMEOUT value.
- One natural sub-module: bus_timeout_counter, with clear/enable/expire and parameter TIMEOUT.
- Everything else stays in mem_bus_arbiter.

Test Plan:
- Reset, then inst_ren=1, addr=0x100; bus_ack in the 1st bus_req cycle with rdata=0x2408000A:
  - bus_req=1 in cycle 1, addr=0x100.
  - stall=1 in cycles 0-1, stall=0 in cycle 2.
  - inst_data=0x2408000A.
- inst_ren=1 at 0x104 and mem_ren=1 at 0x2000, both in the same cycle; ack after 3 wait cycles each:
  - Bus order is 0x2000 then 0x104, with exactly one idle cycle between.
  - stall stays 1 until both are done; mem_din and inst_data both correct.
- mem_wen=1, addr=0x40, dout=0xDEADBEEF:
  - bus_we=1, bus_wdata=0xDEADBEEF.
  - mem_din keeps its prior value; stall drops the cycle after ack.
- bus_ack never asserted, TIMEOUT=16:
  - bus_req held exactly 16 cycles, then bus_err=1 and read data=0.
  - stall released; bus_err remains 1 until rst.
- rst asserted while in DATA with bus_req=1:
  - Next cycle bus_req=0 and all outputs 0.
  - A late bus_ack arriving in IDLE causes no state change.
- inst_ren dropped (flush) during INST wait:
  - Ack completes the transaction; inst_data unchanged and stall=0.
  - A following request to 0x200 is issued fresh.
